// File: rtl/output_port_scheduler_if.sv
// Bundle of flit inputs, credit return and scheduler outputs for one router output port.
interface output_port_scheduler_if;
    logic [3:0][13:0] data;          // per input: {header[1:0], flit[11:0]}
    logic [3:0]       valid;
    logic [3:0]       tail;
    logic             credit_in;
    logic [3:0]       port_block;
    logic [1:0]       mux_select;
    logic [11:0]      output_data;
    logic             out_valid;
    logic             busy;
    logic             credit_err;

    // Side that drives flits and credits into the scheduler
    modport master (
        output data, valid, tail, credit_in,
        input  port_block, mux_select, output_data, out_valid, busy, credit_err
    );

    // The scheduler itself
    modport slave (
        input  data, valid, tail, credit_in,
        output port_block, mux_select, output_data, out_valid, busy, credit_err
    );
endinterface

// File: rtl/output_port_scheduler.sv
// Output-port scheduler: packet-granular round-robin arbitration among four inputs,
// credit-based flow control toward the downstream buffer, registered flit output.
module output_port_scheduler #(
    parameter logic [1:0] PORT_ADDR = 2'b01,
    parameter int         CREDITS   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    output_port_scheduler_if.slave   sched
);
    localparam int         FLIT_WIDTH = 12;
    localparam logic [2:0] CREDIT_MAX = 3'(CREDITS);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]            state_reg;
    logic [1:0]            owner_reg;
    logic [1:0]            rr_ptr_reg;
    logic [2:0]            credits_reg;
    logic [1:0]            mux_select_reg;
    logic [FLIT_WIDTH-1:0] output_data_reg;
    logic                  out_valid_reg;
    logic                  credit_err_reg;

    logic [3:0] req;
    logic [1:0] winner;
    logic [1:0] idx;
    logic       any_req;
    logic [1:0] source;
    logic       fire;
    logic       src_tail;
    logic       has_credit;

    // A flit only asks for this port when its header addresses it
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_req
            assign req[gi] = sched.valid[gi] & (sched.data[gi][13:12] == PORT_ADDR);
        end
    endgenerate

    // Round-robin pick: scan downwards so the first request at/after rr_ptr is the last written
    always_comb begin
        winner  = rr_ptr_reg;
        any_req = 1'b0;
        idx     = rr_ptr_reg;
        for (int k = 3; k >= 0; k--) begin
            idx = rr_ptr_reg + 2'(k);
            if (req[idx]) begin
                winner  = idx;
                any_req = 1'b1;
            end
        end
    end

    assign has_credit = (credits_reg != 3'd0);

    // Transfer decision: the locked owner ignores headers on body flits
    always_comb begin
        source = winner;
        fire   = 1'b0;
        if (state_reg == LOCKED) begin
            source = owner_reg;
            fire   = sched.valid[owner_reg] & has_credit;
        end else begin
            fire   = any_req & has_credit;
        end
    end

    assign src_tail = sched.tail[source];

    // Back-pressure: every requester that does not transfer this cycle is held off
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_block
            assign sched.port_block[gi] = req[gi] & ~(fire & (source == 2'(gi)));
        end
    endgenerate

    // Packet lock: held from head flit until the owner's tail flit transfers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            owner_reg  <= 2'd0;
            rr_ptr_reg <= 2'd0;
        end else if (fire) begin
            if (src_tail) begin
                state_reg  <= IDLE;
                rr_ptr_reg <= source + 2'd1;
            end else begin
                state_reg  <= LOCKED;
                owner_reg  <= source;
            end
        end
    end

    // Registered output stage: one-cycle latency, data held when nothing fires
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg   <= 1'b0;
            output_data_reg <= '0;
            mux_select_reg  <= 2'd0;
        end else begin
            out_valid_reg <= fire;
            if (fire) begin
                output_data_reg <= sched.data[source][FLIT_WIDTH-1:0];
                mux_select_reg  <= source;
            end
        end
    end

    // Downstream credit counter; a return while already full saturates and flags an error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits_reg    <= CREDIT_MAX;
            credit_err_reg <= 1'b0;
        end else begin
            if (fire && !sched.credit_in) begin
                credits_reg <= credits_reg - 3'd1;
            end else if (!fire && sched.credit_in) begin
                if (credits_reg == CREDIT_MAX) begin
                    credit_err_reg <= 1'b1;
                end else begin
                    credits_reg <= credits_reg + 3'd1;
                end
            end
        end
    end

    assign sched.mux_select  = mux_select_reg;
    assign sched.output_data = output_data_reg;
    assign sched.out_valid   = out_valid_reg;
    assign sched.busy        = (state_reg == LOCKED);
    assign sched.credit_err  = credit_err_reg;
endmodule

// File: tb/tb_output_port_scheduler.sv
// Bench for output_port_scheduler: hand-computed vector table, directed multi-cycle
// sequences and randomized traffic checked against a packet-level reference model.
module tb_output_port_scheduler;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    output_port_scheduler_if bus ();

    output_port_scheduler #(.PORT_ADDR(2'b01), .CREDITS(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .sched (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (packet level) ----------------
    int          m_owner;   // -1 when no packet holds the port
    int          m_rr;
    int          m_cred;
    bit          m_err;
    bit          m_ov;
    logic [11:0] m_data;
    int          m_sel;

    task automatic model_reset();
        m_owner = -1; m_rr = 0; m_cred = 4; m_err = 0;
        m_ov = 0; m_data = 12'h000; m_sel = 0;
    endtask

    task automatic model_eval(output bit fire, output int src, output logic [3:0] blk);
        bit [3:0] rq;
        for (int i = 0; i < 4; i++) rq[i] = bus.valid[i] && (bus.data[i][13:12] == 2'b01);
        fire = 0;
        src  = -1;
        if (m_owner >= 0) begin
            if (bus.valid[m_owner] && m_cred > 0) begin
                fire = 1;
                src  = m_owner;
            end
        end else if (m_cred > 0) begin
            for (int k = 0; k < 4; k++)
                if (src < 0 && rq[(m_rr + k) % 4]) src = (m_rr + k) % 4;
            fire = (src >= 0);
        end
        for (int i = 0; i < 4; i++) blk[i] = rq[i] && !(fire && src == i);
    endtask

    task automatic model_step(input bit fire, input int src);
        int delta;
        m_ov = fire;
        if (fire) begin
            m_data = bus.data[src][11:0];
            m_sel  = src;
            if (bus.tail[src]) begin
                m_owner = -1;
                m_rr    = (src + 1) % 4;
            end else begin
                m_owner = src;
            end
        end
        delta = (fire ? -1 : 0) + (bus.credit_in ? 1 : 0);
        if (!fire && bus.credit_in && m_cred == 4) m_err = 1;
        else m_cred += delta;
    endtask

    // One clock with inputs already driven: block checked mid-cycle, registers after the edge
    task automatic run_cycle(input string tag, output bit fired);
        bit f; int s; logic [3:0] blk;
        model_eval(f, s, blk);
        @(negedge clk);
        check({tag, ".block"}, 32'(bus.port_block), 32'(blk));
        @(posedge clk);
        model_step(f, s);
        #1;
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_ov));
        check({tag, ".data"}, 32'(bus.output_data), 32'(m_data));
        check({tag, ".sel"}, 32'(bus.mux_select), 32'(m_sel));
        check({tag, ".busy"}, 32'(bus.busy), 32'(m_owner >= 0));
        check({tag, ".err"}, 32'(bus.credit_err), 32'(m_err));
        fired = f;
    endtask

    task automatic drive_idle();
        bus.valid = '0; bus.tail = '0; bus.data = '0; bus.credit_in = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        drive_idle();
        rst = 1'b1;
        @(posedge clk); #1;
        check({tag, ".rst_ov"}, 32'(bus.out_valid), 32'd0);
        check({tag, ".rst_data"}, 32'(bus.output_data), 32'd0);
        check({tag, ".rst_sel"}, 32'(bus.mux_select), 32'd0);
        check({tag, ".rst_busy"}, 32'(bus.busy), 32'd0);
        check({tag, ".rst_err"}, 32'(bus.credit_err), 32'd0);
        rst = 1'b0;
        model_reset();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]       valid;
        logic [3:0]       tail;
        logic [3:0][13:0] data;
        logic             ci;
        logic [3:0]       blk;
        logic             ov;
        logic [11:0]      od;
        logic [1:0]       sel;
        logic             busy;
        logic             err;
    } vec_t;

    function automatic vec_t mkv(input logic [3:0] v, input logic [3:0] t,
                                 input logic [13:0] d0, input logic [13:0] d1, input logic ci,
                                 input logic [3:0] blk, input logic ov, input logic [11:0] od,
                                 input logic [1:0] sel, input logic busy, input logic err);
        vec_t r;
        r.valid = v; r.tail = t; r.data = '0; r.data[0] = d0; r.data[1] = d1;
        r.ci = ci; r.blk = blk; r.ov = ov; r.od = od; r.sel = sel; r.busy = busy; r.err = err;
        return r;
    endfunction

    vec_t tbl[13];

    initial begin
        bit f;
        int k;
        int nout;
        int order[6];

        // port2 3-flit packet, then header filtering, credit exhaustion and saturation
        tbl[0]  = mkv(4'b0010, 4'b0000, 14'h0000, 14'h1111, 0, 4'b0000, 1, 12'h111, 2'd1, 1, 0);
        tbl[1]  = mkv(4'b0010, 4'b0000, 14'h0000, 14'h1222, 0, 4'b0000, 1, 12'h222, 2'd1, 1, 0);
        tbl[2]  = mkv(4'b0010, 4'b0010, 14'h0000, 14'h1333, 0, 4'b0000, 1, 12'h333, 2'd1, 0, 0);
        tbl[3]  = mkv(4'b0000, 4'b0000, 14'h0000, 14'h0000, 0, 4'b0000, 0, 12'h333, 2'd1, 0, 0);
        tbl[4]  = mkv(4'b0011, 4'b0011, 14'h2AAA, 14'h1444, 0, 4'b0000, 1, 12'h444, 2'd1, 0, 0);
        tbl[5]  = mkv(4'b0011, 4'b0011, 14'h2AAA, 14'h1444, 0, 4'b0010, 0, 12'h444, 2'd1, 0, 0);
        tbl[6]  = mkv(4'b0011, 4'b0011, 14'h2AAA, 14'h1444, 1, 4'b0010, 0, 12'h444, 2'd1, 0, 0);
        tbl[7]  = mkv(4'b0011, 4'b0011, 14'h2AAA, 14'h1555, 0, 4'b0000, 1, 12'h555, 2'd1, 0, 0);
        for (int i = 8; i < 12; i++)
            tbl[i] = mkv(4'b0000, 4'b0000, 14'h0000, 14'h0000, 1, 4'b0000, 0, 12'h555, 2'd1, 0, 0);
        tbl[12] = mkv(4'b0000, 4'b0000, 14'h0000, 14'h0000, 1, 4'b0000, 0, 12'h555, 2'd1, 0, 1);

        rst = 1'b1;
        drive_idle();
        @(posedge clk); #1;
        do_reset("t1");

        for (int i = 0; i < 13; i++) begin
            bus.valid = tbl[i].valid; bus.tail = tbl[i].tail;
            bus.data = tbl[i].data;   bus.credit_in = tbl[i].ci;
            @(negedge clk);
            check($sformatf("tbl%0d.block", i), 32'(bus.port_block), 32'(tbl[i].blk));
            @(posedge clk); #1;
            check($sformatf("tbl%0d.out_valid", i), 32'(bus.out_valid), 32'(tbl[i].ov));
            check($sformatf("tbl%0d.data", i), 32'(bus.output_data), 32'(tbl[i].od));
            check($sformatf("tbl%0d.sel", i), 32'(bus.mux_select), 32'(tbl[i].sel));
            check($sformatf("tbl%0d.busy", i), 32'(bus.busy), 32'(tbl[i].busy));
            check($sformatf("tbl%0d.err", i), 32'(bus.credit_err), 32'(tbl[i].err));
            $display("tbl %0d: valid=%b ci=%b -> blk=%b ov=%b data=%h sel=%0d",
                     i, tbl[i].valid, tbl[i].ci, bus.port_block, bus.out_valid,
                     bus.output_data, bus.mux_select);
        end

        // ports 1,3,4 contend with single-flit packets; round-robin order 1,3,4,1,3,4
        do_reset("t2");
        order = '{0, 2, 3, 0, 2, 3};
        for (int c = 0; c < 6; c++) begin
            bus.valid = 4'b1101; bus.tail = 4'b1101; bus.credit_in = 1'b1;
            for (int p = 0; p < 4; p++) bus.data[p] = {2'b01, 12'($urandom)};
            run_cycle($sformatf("rr%0d", c), f);
            check($sformatf("rr%0d.order", c), 32'(bus.mux_select), 32'(order[c]));
            $display("rr %0d: granted port%0d", c, bus.mux_select + 1);
        end

        // 6-flit packet with only 4 credits: stall until two credits return
        do_reset("t4");
        k = 0; nout = 0;
        for (int c = 0; c < 12 && k < 6; c++) begin
            bus.valid = 4'b0001; bus.tail = {3'b000, k == 5};
            bus.data[0] = {2'b01, 12'(16'h0A0 + k)};
            bus.credit_in = (c == 6 || c == 8);
            run_cycle($sformatf("stall%0d", c), f);
            if (bus.out_valid) nout++;
            if (c == 4 || c == 5) check($sformatf("stall%0d.blk1", c), 32'(bus.port_block[0]), 32'd1);
            if (f) k++;
            $display("stall %0d: fired=%0d flits_out=%0d", c, f, nout);
        end
        drive_idle();
        @(negedge clk);
        check("stall.flits_out", 32'(nout), 32'd6);
        check("stall.idle", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        model_step(1'b0, 0);

        // port3 owns the port while port1 waits; lock release hands over to port1
        do_reset("t5");
        for (int c = 0; c < 4; c++) begin
            drive_idle();
            if (c < 3) begin
                bus.valid[2] = 1'b1; bus.tail[2] = (c == 2);
                bus.data[2] = {(c == 0) ? 2'b01 : 2'b11, 12'(16'h300 + c)};
            end
            if (c > 0) begin
                bus.valid[0] = 1'b1; bus.tail[0] = 1'b1; bus.data[0] = {2'b01, 12'h100};
            end
            run_cycle($sformatf("own%0d", c), f);
            $display("own %0d: sel=%0d busy=%b data=%h", c, bus.mux_select, bus.busy, bus.output_data);
        end
        check("own.handover", 32'(bus.mux_select), 32'd0);

        // reset in the middle of a locked packet, then a credit return at full
        do_reset("t6");
        for (int c = 0; c < 2; c++) begin
            bus.valid = 4'b0010; bus.tail = 4'b0000; bus.data[1] = {2'b01, 12'(16'h600 + c)};
            run_cycle($sformatf("mid%0d", c), f);
        end
        bus.data[1] = {2'b01, 12'h602};
        #2 rst = 1'b1;
        #1;
        check("mid.rst_ov", 32'(bus.out_valid), 32'd0);
        check("mid.rst_data", 32'(bus.output_data), 32'd0);
        check("mid.rst_busy", 32'(bus.busy), 32'd0);
        check("mid.rst_sel", 32'(bus.mux_select), 32'd0);
        drive_idle();
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        $display("mid: reset during lock, ov=%b busy=%b", bus.out_valid, bus.busy);
        for (int c = 0; c < 4; c++) begin
            drive_idle();
            bus.credit_in = (c == 0);
            run_cycle($sformatf("err%0d", c), f);
            check($sformatf("err%0d.sticky", c), 32'(bus.credit_err), 32'd1);
            $display("err %0d: credit_err=%b", c, bus.credit_err);
        end

        // randomized traffic against the reference model
        do_reset("rnd");
        for (int c = 0; c < 1500; c++) begin
            for (int p = 0; p < 4; p++) begin
                bus.valid[p] = ($urandom_range(0, 9) < 6);
                bus.tail[p]  = ($urandom_range(0, 9) < 3);
                bus.data[p]  = {($urandom_range(0, 3) < 2) ? 2'b01 : 2'($urandom), 12'($urandom)};
            end
            bus.credit_in = ($urandom_range(0, 9) < 4);
            run_cycle($sformatf("rnd%0d", c), f);
            $display("rnd %0d: valid=%b blk=%b ov=%b data=%h sel=%0d busy=%b",
                     c, bus.valid, bus.port_block, bus.out_valid, bus.output_data,
                     bus.mux_select, bus.busy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
